// File: rtl/snn_layer_wta.sv
// Layer of P_N integrate-and-fire neurons on a shared P_S-bit event bus with leak and refractory period.
// Events are integrated one synapse per cycle; mode 0 is winner-take-all, mode 1 fires neurons independently.
module snn_layer_wta #(
    parameter int unsigned P_N      = 8,
    parameter int unsigned P_S      = 42,
    parameter int unsigned P_WIDTH  = 8,
    parameter int unsigned P_SHIFT  = 8,
    parameter int unsigned P_ACC_W  = P_WIDTH + P_SHIFT + 6,
    parameter int unsigned P_LEAK   = 4,
    parameter int unsigned P_REFRAC = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [P_S-1:0]                i_event,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_mode,
    input  logic [P_N*P_S*P_WIDTH-1:0]    i_weight,
    input  logic [P_N*P_ACC_W-1:0]        i_threshold,
    output logic [P_N-1:0]                o_spike,
    output logic [$clog2(P_N)-1:0]        o_winner,
    output logic                          o_fired,
    output logic                          o_valid
);

    localparam int unsigned WIN_W = $clog2(P_N);
    localparam int unsigned SYN_W = (P_S > 1) ? $clog2(P_S) : 1;
    localparam int unsigned RC_W  = (P_REFRAC > 1) ? $clog2(P_REFRAC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAK, S_ACCUM, S_CMP, S_FIRE, S_REFRAC
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic [P_S-1:0]       r_event;
    logic                 r_mode;
    logic [SYN_W-1:0]     r_syn;
    logic [RC_W-1:0]      r_rc;
    logic [P_ACC_W-1:0]   r_pot [P_N];
    logic [P_N-1:0]       r_spike;
    logic [WIN_W-1:0]     r_win;
    logic                 r_fired;
    logic                 r_valid;

    logic                 w_bit;
    logic [P_ACC_W-1:0]   w_leaked [P_N];
    logic [P_ACC_W:0]     w_sum    [P_N];
    logic [P_ACC_W-1:0]   w_accum  [P_N];
    logic [P_N-1:0]       w_elig;
    logic [WIN_W-1:0]     w_win;
    logic                 w_any;
    logic [P_ACC_W-1:0]   w_best;

    // Per-neuron leak, saturating accumulate and winner search over the current potentials
    always_comb begin
        w_bit  = r_event[r_syn];
        w_any  = 1'b0;
        w_win  = '0;
        w_best = '0;
        w_elig = '0;
        for (int n = 0; n < int'(P_N); n++) begin
            w_leaked[n] = (P_LEAK == 0) ? r_pot[n] : r_pot[n] - (r_pot[n] >> P_LEAK);
            w_sum[n]    = {1'b0, r_pot[n]}
                        + ((P_ACC_W + 1)'(i_weight[(n * int'(P_S) + int'(32'(r_syn))) * int'(P_WIDTH) +: P_WIDTH])
                           << P_SHIFT);
            w_accum[n]  = w_sum[n][P_ACC_W] ? '1 : w_sum[n][P_ACC_W-1:0];
            w_elig[n]   = r_pot[n] >= i_threshold[n * int'(P_ACC_W) +: P_ACC_W];
            // strict compare keeps the lowest index on ties
            if (w_elig[n] && (!w_any || r_pot[n] > w_best)) begin
                w_any  = 1'b1;
                w_best = r_pot[n];
                w_win  = WIN_W'(n);
            end
        end
    end

    // Sequencer: potentials, latched event and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_event <= '0;
            r_mode  <= 1'b0;
            r_syn   <= '0;
            r_rc    <= '0;
            r_spike <= '0;
            r_win   <= '0;
            r_fired <= 1'b0;
            r_valid <= 1'b0;
            for (int n = 0; n < int'(P_N); n++) r_pot[n] <= '0;
        end else begin
            r_spike <= '0;
            r_win   <= '0;
            r_fired <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_event <= i_event;
                        r_mode  <= i_mode;
                        r_ready <= 1'b0;
                        r_state <= S_LEAK;
                    end
                end
                S_LEAK: begin
                    for (int n = 0; n < int'(P_N); n++) r_pot[n] <= w_leaked[n];
                    r_syn   <= '0;
                    r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_bit) begin
                        for (int n = 0; n < int'(P_N); n++) r_pot[n] <= w_accum[n];
                    end
                    if (r_syn == SYN_W'(P_S - 1)) begin
                        r_state <= S_CMP;
                    end else begin
                        r_syn <= r_syn + SYN_W'(1);
                    end
                end
                S_CMP: begin
                    r_valid <= 1'b1;
                    r_fired <= w_any;
                    r_win   <= w_win;
                    r_spike <= r_mode ? w_elig : (w_any ? (P_N'(1) << w_win) : '0);
                    r_state <= S_FIRE;
                end
                S_FIRE: begin
                    // WTA clears the whole layer on a spike; independent mode clears only spikers
                    for (int n = 0; n < int'(P_N); n++) begin
                        if ((!r_mode && r_fired) || r_spike[n]) r_pot[n] <= '0;
                    end
                    if (P_REFRAC == 0) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rc    <= RC_W'(P_REFRAC - 1);
                        r_state <= S_REFRAC;
                    end
                end
                S_REFRAC: begin
                    if (r_rc == '0) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rc <= r_rc - RC_W'(1);
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_spike  = r_spike;
    assign o_winner = r_win;
    assign o_fired  = r_fired;
    assign o_valid  = r_valid;

endmodule

// File: tb/tb_snn_layer_wta.sv
// Scoreboard bench for snn_layer_wta: directed scenarios followed by random events,
// checked against an arithmetic model of leak, saturating integration and winner selection.
module tb_snn_layer_wta;

    localparam int N  = 4;
    localparam int S  = 42;
    localparam int WD = 8;
    localparam int SH = 8;
    localparam int AW = WD + SH + 6;
    localparam int LK = 1;
    localparam int RF = 4;
    localparam longint PMAX = (64'd1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [S-1:0]         i_event;
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_mode;
    logic [N*S*WD-1:0]    i_weight;
    logic [N*AW-1:0]      i_threshold;
    logic [N-1:0]         o_spike;
    logic [1:0]           o_winner;
    logic                 o_fired;
    logic                 o_valid;

    snn_layer_wta #(
        .P_N(N), .P_S(S), .P_WIDTH(WD), .P_SHIFT(SH), .P_ACC_W(AW), .P_LEAK(LK), .P_REFRAC(RF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_event(i_event), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_weight(i_weight), .i_threshold(i_threshold), .o_spike(o_spike),
        .o_winner(o_winner), .o_fired(o_fired), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    int     w   [N][S];
    longint thr [N];
    longint pot [N];

    always_comb begin
        for (int n = 0; n < N; n++) begin
            for (int s = 0; s < S; s++) i_weight[(n*S+s)*WD +: WD] = WD'(w[n][s]);
            i_threshold[n*AW +: AW] = AW'(thr[n]);
        end
    end

    typedef struct {
        logic [N-1:0] spike;
        logic [1:0]   win;
        logic         fired;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int cnt    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
        end
    endtask

    // Monitor: every o_valid must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk("valid_without_stimulus", q.size(), 1);
                end else begin
                    mon_e = q.pop_front();
                    chk("spike", o_spike, mon_e.spike);
                    chk("winner", o_winner, mon_e.win);
                    chk("fired", o_fired, mon_e.fired);
                    chk("valid_cycle", cnt, mon_e.cyc);
                end
            end else begin
                chk("spike_idle", o_spike, 0);
                chk("fired_idle", o_fired, 0);
            end
        end
    end

    // Reference: one whole evaluation in plain arithmetic
    task automatic model_eval(input logic [S-1:0] ev, input logic md, output exp_t e);
        longint sum;
        logic [N-1:0] el;
        int best;
        best = -1;
        el   = '0;
        for (int n = 0; n < N; n++) begin
            if (LK > 0) pot[n] = pot[n] - (pot[n] >> LK);
            sum = 0;
            for (int s = 0; s < S; s++) if (ev[s]) sum += longint'(w[n][s]) << SH;
            pot[n] = (pot[n] + sum > PMAX) ? PMAX : pot[n] + sum;
        end
        for (int n = 0; n < N; n++) begin
            el[n] = (pot[n] >= thr[n]);
            if (el[n] && (best < 0 || pot[n] > pot[best])) best = n;
        end
        e.fired = (best >= 0);
        e.win   = e.fired ? 2'(best) : 2'd0;
        e.spike = md ? el : (e.fired ? 4'(1 << best) : 4'd0);
        for (int n = 0; n < N; n++) begin
            if ((!md && e.fired) || e.spike[n]) pot[n] = 0;
        end
    endtask

    task automatic wait_ready(input string nm);
        for (int k = 0; k < 200 && !o_ready; k++) @(negedge clk);
        if (!o_ready) chk(nm, o_ready, 1);
    endtask

    // Issue one event at a negedge; optionally keep i_valid asserted through refractory
    task automatic send(input logic [S-1:0] ev, input logic md, input logic hold);
        exp_t e;
        int acc;
        wait_ready("ready_timeout_pre");
        i_event = ev;
        i_mode  = md;
        i_valid = 1'b1;
        acc     = cnt + 1;
        model_eval(ev, md, e);
        e.cyc   = acc + S + 2;
        q.push_back(e);
        @(negedge clk);
        if (!hold) i_valid = 1'b0;
        chk("ready_low_after_accept", o_ready, 0);
        wait_ready("ready_timeout_post");
        chk("ready_return_cycle", cnt, acc + S + 3 + RF);
        i_valid = 1'b0;
    endtask

    task automatic set_w(input int v);
        for (int n = 0; n < N; n++) for (int s = 0; s < S; s++) w[n][s] = v;
    endtask

    task automatic set_thr(input longint t0, input longint t1, input longint t2, input longint t3);
        thr[0] = t0; thr[1] = t1; thr[2] = t2; thr[3] = t3;
    endtask

    initial begin
        logic [S-1:0] ev;
        int acc;
        rst = 1'b1; i_valid = 1'b0; i_event = '0; i_mode = 1'b0;
        set_w(0);
        set_thr(0, 0, 0, 0);
        for (int n = 0; n < N; n++) pot[n] = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_spike", o_spike, 0);
        chk("rst_winner", o_winner, 0);
        chk("rst_fired", o_fired, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_ready, 1);

        // Graded weights, only the strongest neuron crosses 0x2000
        for (int n = 0; n < N; n++) for (int s = 0; s < S; s++) w[n][s] = n + 1;
        set_thr(64'h2000, 64'h2000, 64'h2000, 64'h2000);
        ev = '0; ev[9:0] = '1;
        send(ev, 1'b0, 1'b0);

        // Tie at zero threshold with an empty event; i_valid held through refractory
        set_w(16'h10);
        set_thr(0, 0, 0, 0);
        send('0, 1'b0, 1'b1);

        // Independent mode: neurons 2,3 fire, 0,1 retain, then retained charge fires alone
        for (int n = 0; n < N; n++) for (int s = 0; s < S; s++) w[n][s] = $urandom_range(1, 255);
        set_thr(PMAX, PMAX, 0, 0);
        ev = S'({$urandom, $urandom}); ev[0] = 1'b1;
        send(ev, 1'b1, 1'b0);
        set_thr(1, 1, PMAX, PMAX);
        send('0, 1'b1, 1'b0);

        // Build charge, then reset in ACCUM synapse 10 must abort silently
        set_thr(PMAX, PMAX, PMAX, PMAX);
        send(S'({$urandom, $urandom}) | S'(1), 1'b0, 1'b0);
        wait_ready("ready_timeout_rst");
        i_event = '1; i_mode = 1'b0; i_valid = 1'b1;
        acc = cnt + 1;
        @(negedge clk);
        i_valid = 1'b0;
        while (cnt < acc + 11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < N; n++) pot[n] = 0;
        chk("ready_after_abort", o_ready, 1);
        chk("valid_after_abort", o_valid, 0);
        repeat (60) @(negedge clk);
        set_thr(1, 1, 1, 1);
        send('0, 1'b0, 1'b0);

        // Saturation over three full events at maximum threshold
        set_w(8'hFF);
        set_thr(PMAX, PMAX, PMAX, PMAX);
        repeat (3) send('1, 1'b0, 1'b0);

        // Leak: 0x1000 halves to 0x800, exactly at neuron 0's threshold
        set_w(16'h10);
        send(S'(1), 1'b0, 1'b0);
        set_thr(64'h800, 64'h801, PMAX, PMAX);
        send('0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            for (int n = 0; n < N; n++) begin
                for (int s = 0; s < S; s++) w[n][s] = $urandom_range(0, 255);
                thr[n] = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(0, 3000000));
            end
            ev = ($urandom_range(0, 5) == 0) ? '0 : S'({$urandom, $urandom});
            send(ev, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (60) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
